// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-select stage between decode and the ALU. For every ALU-using opcode
// class it builds the two ALU operands (DATA0/DATA1) and the ALU op select,
// resolves read-after-write hazards by forwarding from NUM_FWD later stages,
// and stalls while the selected forwarding channel still has a pending result
// (for example an outstanding load). One instruction is held in an output
// register with valid/ready handshakes on both sides.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   FLUSH                 drop the held instruction and refuse the incoming one
//   IN_VALID / IN_READY   decode-side handshake (IN_READY is combinational)
//   OPCODE, FUNCT3, FUNCT1  instruction fields (FUNCT1 = instruction bit 30)
//   RS1, RS2              source register indices
//   RS1_DATA, RS2_DATA    register-file read data
//   PC                    instruction PC
//   IMM12, U_IMM20        I/S immediate and U immediate from decode
//   FWD_VALID/PEND/RD/DATA  per-channel forwarding info, channel 0 youngest
//   OUT_VALID / OUT_READY ALU-side handshake
//   DATA0, DATA1          registered ALU operands
//   ALU_EN                registered: instruction needs the ALU
//   ALU_FUNCT3, ALU_ALT   registered op select (ALT selects SUB/SRA/compare)
//   STALL_CNT             saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int N       = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 FLUSH,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [6:0]           OPCODE,
    input  logic [2:0]           FUNCT3,
    input  logic                 FUNCT1,
    input  logic [4:0]           RS1,
    input  logic [4:0]           RS2,
    input  logic [N-1:0]         RS1_DATA,
    input  logic [N-1:0]         RS2_DATA,
    input  logic [N-1:0]         PC,
    input  logic [11:0]          IMM12,
    input  logic [19:0]          U_IMM20,
    input  logic [NUM_FWD-1:0]   FWD_VALID,
    input  logic [NUM_FWD-1:0]   FWD_PEND,
    input  logic [5*NUM_FWD-1:0] FWD_RD,
    input  logic [N*NUM_FWD-1:0] FWD_DATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [N-1:0]         DATA0,
    output logic [N-1:0]         DATA1,
    output logic                 ALU_EN,
    output logic [2:0]           ALU_FUNCT3,
    output logic                 ALU_ALT,
    output logic [CNT_W-1:0]     STALL_CNT
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [N-1:0]     ZERO_N   = {N{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Output register occupancy.
    typedef enum logic {
        EMPTY_ST = 1'b0,
        FULL_ST  = 1'b1
    } state_t;

    // Result of resolving one source operand: value to use and whether the
    // selected forwarding channel still has its result outstanding.
    typedef struct packed {
        logic         haz;
        logic [N-1:0] val;
    } src_t;

    // Resolve a source register: x0 reads zero; otherwise the lowest (youngest)
    // matching valid channel wins, and only that channel's pending flag counts.
    function automatic src_t resolve_src(input logic [4:0] idx, input logic [N-1:0] rf_data);
        src_t res;
        logic found;
        res   = '{haz: 1'b0, val: rf_data};
        found = 1'b0;
        if (idx == 5'd0) begin
            res.val = ZERO_N;
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!found && FWD_VALID[i] && (FWD_RD[5*i +: 5] == idx)) begin
                    found   = 1'b1;
                    res.haz = FWD_PEND[i];
                    res.val = FWD_DATA[N*i +: N];
                end else begin
                    found = found;
                end
            end
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [N-1:0]     data0_r;
    logic [N-1:0]     data1_r;
    logic             alu_en_r;
    logic [2:0]       alu_funct3_r;
    logic             alu_alt_r;
    logic [CNT_W-1:0] stall_cnt_r;

    src_t             rs1_src_s;
    src_t             rs2_src_s;
    logic             use_rs1_s;
    logic             use_rs2_s;
    logic             hazard_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             stall_inc_s;

    logic [N-1:0]     imm_sext_s;
    logic [N-1:0]     shamt_s;
    logic [N-1:0]     u_imm_s;
    logic [N-1:0]     link_ofs_s;

    logic [N-1:0]     nxt_data0_s;
    logic [N-1:0]     nxt_data1_s;
    logic             nxt_alu_en_s;
    logic [2:0]       nxt_funct3_s;
    logic             nxt_alt_s;

    // Immediate forms used by the various opcode classes.
    always_comb begin
        imm_sext_s = N'($signed(IMM12));
        shamt_s    = N'(IMM12[4:0]);
        u_imm_s    = N'($signed({U_IMM20, 12'h000}));
        link_ofs_s = N'(3'd4);
    end

    // Forwarding / register-file resolution for both sources.
    always_comb begin
        rs1_src_s = resolve_src(RS1, RS1_DATA);
        rs2_src_s = resolve_src(RS2, RS2_DATA);
    end

    // Opcode decode: source usage and next operand / op-select values.
    always_comb begin
        use_rs1_s    = 1'b0;
        use_rs2_s    = 1'b0;
        nxt_alu_en_s = 1'b1;
        nxt_data0_s  = ZERO_N;
        nxt_data1_s  = ZERO_N;
        nxt_funct3_s = 3'b000;
        nxt_alt_s    = 1'b0;
        case (OPCODE)
            OPC_OP_IMM: begin
                use_rs1_s    = 1'b1;
                nxt_data0_s  = rs1_src_s.val;
                nxt_funct3_s = FUNCT3;
                if ((FUNCT3 == 3'b001) || (FUNCT3 == 3'b101)) begin
                    // Shift-immediate: shamt only; bit 10 selects arithmetic.
                    nxt_data1_s = shamt_s;
                    nxt_alt_s   = IMM12[10];
                end else begin
                    nxt_data1_s = imm_sext_s;
                    nxt_alt_s   = 1'b0;
                end
            end
            OPC_OP: begin
                use_rs1_s    = 1'b1;
                use_rs2_s    = 1'b1;
                nxt_data0_s  = rs1_src_s.val;
                nxt_data1_s  = rs2_src_s.val;
                nxt_funct3_s = FUNCT3;
                nxt_alt_s    = FUNCT1;
            end
            OPC_LOAD, OPC_STORE: begin
                // Address generation is always an add.
                use_rs1_s   = 1'b1;
                nxt_data0_s = rs1_src_s.val;
                nxt_data1_s = imm_sext_s;
            end
            OPC_LUI: begin
                nxt_data1_s = u_imm_s;
            end
            OPC_AUIPC: begin
                nxt_data0_s = PC;
                nxt_data1_s = u_imm_s;
            end
            OPC_JAL: begin
                nxt_data0_s = PC;
                nxt_data1_s = link_ofs_s;
            end
            OPC_JALR: begin
                // The ALU computes the link PC+4, but rs1 is still read for the
                // jump target, so it participates in hazard detection.
                use_rs1_s   = 1'b1;
                nxt_data0_s = PC;
                nxt_data1_s = link_ofs_s;
            end
            OPC_BRANCH: begin
                use_rs1_s    = 1'b1;
                use_rs2_s    = 1'b1;
                nxt_data0_s  = rs1_src_s.val;
                nxt_data1_s  = rs2_src_s.val;
                nxt_funct3_s = FUNCT3;
                nxt_alt_s    = 1'b1;
            end
            default: begin
                nxt_alu_en_s = 1'b0;
            end
        endcase
    end

    // Hazard, input handshake and stall-count qualification.
    always_comb begin
        hazard_s = (use_rs1_s && rs1_src_s.haz) || (use_rs2_s && rs2_src_s.haz);
        if (reset || FLUSH || hazard_s) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (state_r == EMPTY_ST) || OUT_READY;
        end
        accept_s    = IN_VALID && in_ready_s;
        stall_inc_s = IN_VALID && hazard_s && !FLUSH;
    end

    // Next-state logic for the output register occupancy.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            EMPTY_ST: begin
                if (FLUSH) begin
                    next_state_s = EMPTY_ST;
                end else if (accept_s) begin
                    next_state_s = FULL_ST;
                end else begin
                    next_state_s = EMPTY_ST;
                end
            end
            FULL_ST: begin
                if (FLUSH) begin
                    next_state_s = EMPTY_ST;
                end else if (accept_s) begin
                    // Drain and refill in the same cycle: no bubble.
                    next_state_s = FULL_ST;
                end else if (OUT_READY) begin
                    next_state_s = EMPTY_ST;
                end else begin
                    next_state_s = FULL_ST;
                end
            end
            default: begin
                next_state_s = EMPTY_ST;
            end
        endcase
    end

    // Output register occupancy state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY_ST;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand / op-select payload registers; only written on accept so they
    // stay stable while the ALU back-pressures.
    always_ff @(posedge clk) begin
        if (reset) begin
            data0_r      <= ZERO_N;
            data1_r      <= ZERO_N;
            alu_en_r     <= 1'b0;
            alu_funct3_r <= 3'b000;
            alu_alt_r    <= 1'b0;
        end else if (accept_s) begin
            data0_r      <= nxt_data0_s;
            data1_r      <= nxt_data1_s;
            alu_en_r     <= nxt_alu_en_s;
            alu_funct3_r <= nxt_funct3_s;
            alu_alt_r    <= nxt_alt_s;
        end else begin
            data0_r      <= data0_r;
            data1_r      <= data1_r;
            alu_en_r     <= alu_en_r;
            alu_funct3_r <= alu_funct3_r;
            alu_alt_r    <= alu_alt_r;
        end
    end

    // Saturating hazard-stall cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign IN_READY   = in_ready_s;
    assign OUT_VALID  = (state_r == FULL_ST);
    assign DATA0      = data0_r;
    assign DATA1      = data1_r;
    assign ALU_EN     = alu_en_r;
    assign ALU_FUNCT3 = alu_funct3_r;
    assign ALU_ALT    = alu_alt_r;
    assign STALL_CNT  = stall_cnt_r;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Self-checking bench for alu_operand_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level reference model that
// computes operands from the opcode rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int N       = 32;
    localparam int NUM_FWD = 2;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct1;
    logic [4:0]           rs1, rs2;
    logic [N-1:0]         rs1_data, rs2_data, pc;
    logic [11:0]          imm12;
    logic [19:0]          u_imm20;
    logic [NUM_FWD-1:0]   fwd_valid, fwd_pend;
    logic [4:0]           ch_rd   [NUM_FWD];
    logic [N-1:0]         ch_data [NUM_FWD];
    logic [5*NUM_FWD-1:0] fwd_rd_bus;
    logic [N*NUM_FWD-1:0] fwd_data_bus;
    logic [N-1:0]         data0, data1;
    logic                 alu_en, alu_alt;
    logic [2:0]           alu_funct3;
    logic [CNT_W-1:0]     stall_cnt;

    // Pack per-channel arrays into the flat forwarding buses.
    always_comb begin
        fwd_rd_bus   = '0;
        fwd_data_bus = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            fwd_rd_bus[5*i +: 5]   = ch_rd[i];
            fwd_data_bus[N*i +: N] = ch_data[i];
        end
    end

    alu_operand_stage #(.N(N), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OPCODE(opcode), .FUNCT3(funct3), .FUNCT1(funct1),
        .RS1(rs1), .RS2(rs2), .RS1_DATA(rs1_data), .RS2_DATA(rs2_data), .PC(pc),
        .IMM12(imm12), .U_IMM20(u_imm20),
        .FWD_VALID(fwd_valid), .FWD_PEND(fwd_pend), .FWD_RD(fwd_rd_bus), .FWD_DATA(fwd_data_bus),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .DATA0(data0), .DATA1(data1), .ALU_EN(alu_en),
        .ALU_FUNCT3(alu_funct3), .ALU_ALT(alu_alt), .STALL_CNT(stall_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic         m_valid, m_known, m_en, m_alt;
    logic [N-1:0] m_d0, m_d1;
    logic [2:0]   m_f3;
    int           m_cnt;

    logic [6:0] op_tab [0:10];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value a source reads: {pending, value}.
    function automatic logic [N:0] ref_src(input logic [4:0] idx, input logic [N-1:0] rf);
        if (idx == 5'd0) return '0;
        for (int i = 0; i < NUM_FWD; i++)
            if (fwd_valid[i] && ch_rd[i] == idx)
                return fwd_pend[i] ? {1'b1, 32'd0} : {1'b0, ch_data[i]};
        return {1'b0, rf};
    endfunction

    function automatic void ref_op(output logic en, output logic [N-1:0] d0, output logic [N-1:0] d1,
                                   output logic [2:0] f3, output logic alt, output logic haz);
        logic [N:0]   s1, s2;
        logic [N-1:0] simm, uimm;
        s1   = ref_src(rs1, rs1_data);
        s2   = ref_src(rs2, rs2_data);
        simm = (imm12 >= 12'd2048) ? ({20'd0, imm12} - 32'd4096) : {20'd0, imm12};
        uimm = {12'd0, u_imm20} * 32'd4096;
        en = 1'b1; d0 = '0; d1 = '0; f3 = 3'd0; alt = 1'b0; haz = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                d0 = s1[N-1:0]; haz = s1[N]; f3 = funct3;
                if (funct3 == 3'd1 || funct3 == 3'd5) begin
                    d1 = {20'd0, imm12} % 32'd32; alt = imm12[10];
                end else d1 = simm;
            end
            OPC_OP:     begin d0 = s1[N-1:0]; d1 = s2[N-1:0]; haz = s1[N] | s2[N]; f3 = funct3; alt = funct1; end
            OPC_LOAD,
            OPC_STORE:  begin d0 = s1[N-1:0]; d1 = simm; haz = s1[N]; end
            OPC_LUI:    d1 = uimm;
            OPC_AUIPC:  begin d0 = pc; d1 = uimm; end
            OPC_JAL:    begin d0 = pc; d1 = 32'd4; end
            OPC_JALR:   begin d0 = pc; d1 = 32'd4; haz = s1[N]; end
            OPC_BRANCH: begin d0 = s1[N-1:0]; d1 = s2[N-1:0]; haz = s1[N] | s2[N]; f3 = funct3; alt = 1'b1; end
            default:    en = 1'b0;
        endcase
    endfunction

    // One clock cycle: check IN_READY against the model, clock, update model,
    // then check registered outputs.
    task automatic step();
        logic en, alt, haz, exp_ready;
        logic [N-1:0] d0, d1;
        logic [2:0] f3;
        #1;
        ref_op(en, d0, d1, f3, alt, haz);
        exp_ready = !reset && !flush && !haz && (!m_valid || out_ready);
        check_eq("in_ready", in_ready, exp_ready);
        @(posedge clk);
        if (reset) begin
            m_valid = 0; m_known = 1; m_d0 = '0; m_d1 = '0; m_en = 0; m_f3 = 0; m_alt = 0; m_cnt = 0;
        end else begin
            if (in_valid && haz && !flush && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                m_valid = 0; m_known = 0;
            end else if (in_valid && exp_ready) begin
                m_valid = 1; m_known = 1; m_d0 = d0; m_d1 = d1; m_en = en; m_f3 = f3; m_alt = alt;
            end else if (m_valid && out_ready) begin
                m_valid = 0; m_known = 0;
            end
        end
        #1;
        check_eq("out_valid", out_valid, m_valid);
        check_eq("stall_cnt", stall_cnt, m_cnt);
        if (m_known) begin
            check_eq("data0", data0, m_d0);
            check_eq("data1", data1, m_d1);
            check_eq("alu_en", alu_en, m_en);
            check_eq("alu_funct3", alu_funct3, m_f3);
            check_eq("alu_alt", alu_alt, m_alt);
        end
    endtask

    task automatic idle();
        reset = 0; flush = 0; in_valid = 0; out_ready = 1;
        opcode = OPC_OP_IMM; funct3 = 0; funct1 = 0; rs1 = 0; rs2 = 0;
        rs1_data = '0; rs2_data = '0; pc = '0; imm12 = '0; u_imm20 = '0;
        fwd_valid = '0; fwd_pend = '0;
        for (int i = 0; i < NUM_FWD; i++) begin ch_rd[i] = 5'd0; ch_data[i] = '0; end
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); reset = 0;
    endtask

    initial begin
        op_tab[0] = OPC_OP_IMM; op_tab[1] = OPC_OP;    op_tab[2]  = OPC_LOAD;
        op_tab[3] = OPC_STORE;  op_tab[4] = OPC_LUI;   op_tab[5]  = OPC_AUIPC;
        op_tab[6] = OPC_JAL;    op_tab[7] = OPC_JALR;  op_tab[8]  = OPC_BRANCH;
        op_tab[9] = 7'h7F;      op_tab[10] = 7'h0F;
        m_valid = 0; m_known = 0; m_d0 = '0; m_d1 = '0; m_en = 0; m_f3 = 0; m_alt = 0; m_cnt = 0;

        do_reset();
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_data0", data0, 32'd0);

        // ADDI x5, x1, -1
        idle(); in_valid = 1; rs1 = 5'd1; rs1_data = 32'd10; imm12 = 12'hFFF; step();
        check_eq("addi_d0", data0, 32'd10);
        check_eq("addi_d1", data1, 32'hFFFF_FFFF);
        check_eq("addi_en", alu_en, 1'b1);
        // SRAI x2, x3, 7
        idle(); in_valid = 1; funct3 = 3'b101; rs1 = 5'd3; rs1_data = 32'h8000_0000; imm12 = 12'h407; step();
        check_eq("srai_d1", data1, 32'd7);
        check_eq("srai_alt", alu_alt, 1'b1);
        // SUB
        idle(); in_valid = 1; opcode = OPC_OP; funct1 = 1; rs1 = 5'd1; rs2 = 5'd2; step();
        check_eq("sub_alt", alu_alt, 1'b1);
        // AUIPC
        idle(); in_valid = 1; opcode = OPC_AUIPC; u_imm20 = 20'd1; pc = 32'h100; step();
        check_eq("auipc_d0", data0, 32'h100);
        check_eq("auipc_d1", data1, 32'h1000);
        // JALR
        idle(); in_valid = 1; opcode = OPC_JALR; pc = 32'h200; step();
        check_eq("jalr_d0", data0, 32'h200);
        check_eq("jalr_d1", data1, 32'd4);
        // ADD x1, x4 with two matching ready channels: youngest wins
        idle(); in_valid = 1; opcode = OPC_OP; rs1 = 5'd1; rs2 = 5'd4; rs2_data = 32'h11;
        fwd_valid = 2'b11; ch_rd[0] = 5'd4; ch_data[0] = 32'hAA; ch_rd[1] = 5'd4; ch_data[1] = 32'hBB; step();
        check_eq("fwd_prio_d1", data1, 32'hAA);
        // x0 is never forwarded
        idle(); in_valid = 1; opcode = OPC_OP; rs1 = 5'd0; rs1_data = 32'h77;
        fwd_valid = 2'b01; ch_rd[0] = 5'd0; ch_data[0] = 32'hCC; step();
        check_eq("x0_d0", data0, 32'd0);

        // Load-use stall for 3 cycles on channel 1
        do_reset();
        idle(); in_valid = 1; rs1 = 5'd6; fwd_valid = 2'b10; fwd_pend = 2'b10; ch_rd[1] = 5'd6;
        for (int c = 0; c < 3; c++) step();
        check_eq("lu_stall_cnt", stall_cnt, 16'd3);
        fwd_pend = 2'b00; ch_data[1] = 32'h55; step();
        check_eq("lu_d0", data0, 32'h55);
        // Same forwarding state but LUI has no sources
        idle(); in_valid = 1; opcode = OPC_LUI; rs1 = 5'd6; fwd_valid = 2'b10; fwd_pend = 2'b10; ch_rd[1] = 5'd6;
        #1; check_eq("lui_no_stall", in_ready, 1'b1);
        step();

        // Back-pressure: hold A while B waits
        idle(); in_valid = 1; imm12 = 12'd5; step();
        out_ready = 0; imm12 = 12'd9;
        for (int c = 0; c < 4; c++) begin
            step();
            check_eq("bp_in_ready", in_ready, 1'b0);
            check_eq("bp_hold_d1", data1, 32'd5);
        end
        out_ready = 1; step();
        check_eq("bp_accept_d1", data1, 32'd9);
        // Flush while full
        flush = 1; imm12 = 12'd3; step();
        check_eq("flush_ov", out_valid, 1'b0);
        idle(); step();
        check_eq("flush_no_capture", out_valid, 1'b0);

        // Reset in the middle of a stall with a full register
        idle(); in_valid = 1; rs1_data = 32'h1234; rs1 = 5'd9; step();
        out_ready = 0; rs1 = 5'd6; fwd_valid = 2'b01; fwd_pend = 2'b01; ch_rd[0] = 5'd6;
        step(); step();
        reset = 1; step();
        check_eq("midrst_ov", out_valid, 1'b0);
        check_eq("midrst_d0", data0, 32'd0);
        check_eq("midrst_cnt", stall_cnt, 16'd0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            opcode    = op_tab[$urandom_range(0, 10)];
            funct3    = 3'($urandom);
            funct1    = 1'($urandom);
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            rs1_data  = $urandom; rs2_data = $urandom; pc = $urandom;
            imm12     = 12'($urandom); u_imm20 = 20'($urandom);
            for (int i = 0; i < NUM_FWD; i++) begin
                fwd_valid[i] = ($urandom_range(0, 1) == 1);
                fwd_pend[i]  = ($urandom_range(0, 2) == 0);
                ch_rd[i]     = 5'($urandom_range(0, 7));
                ch_data[i]   = $urandom;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
